// File: rtl/clk_div_edge_capture.sv
// Multi-channel divided-clock generator with edge-qualified capture of din, all on clk.
// Every capture lands on the same clk edge as the din_q reference flop, and a sticky checker watches that.
module clk_div_edge_capture #(
    parameter int NCH   = 4,
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH-1:0]         enable,
    input  logic [NCH*CNT_W-1:0]   half_per,
    input  logic [NCH*2-1:0]       edge_mode,
    input  logic [WIDTH-1:0]       din,
    output logic [NCH-1:0]         clk_div,
    output logic [NCH-1:0]         rise,
    output logic [NCH-1:0]         fall,
    output logic [NCH*WIDTH-1:0]   cap_data,
    output logic [NCH-1:0]         cap_valid,
    output logic [WIDTH-1:0]       din_q,
    output logic                   err
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic mismatch;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] hcur;
        logic [CNT_W-1:0] h_in;
        logic [CNT_W-1:0] h_eff;
        logic [CNT_W-1:0] h_use;
        logic [1:0]       mode;
        logic [WIDTH-1:0] cap_r;
        logic             en_q;
        logic             level;
        logic             rise_r;
        logic             fall_r;
        logic             cv_r;
        logic             toggle;
        logic             going_up;
        logic             capture;

        // On the first enabled edge hcur is stale, so the fresh half-period is used directly.
        always_comb begin
            h_in     = half_per[i*CNT_W +: CNT_W];
            h_eff    = (h_in == '0) ? ONE : h_in;
            h_use    = en_q ? hcur : h_eff;
            toggle   = enable[i] && (cnt == h_use - ONE);
            mode     = edge_mode[i*2 +: 2];
            going_up = ~level;
            capture  = going_up ? mode[0] : mode[1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt    <= '0;
                hcur   <= '0;
                en_q   <= 1'b0;
                level  <= 1'b0;
                rise_r <= 1'b0;
                fall_r <= 1'b0;
                cv_r   <= 1'b0;
                cap_r  <= '0;
            end else if (!enable[i]) begin
                cnt    <= '0;
                en_q   <= 1'b0;
                rise_r <= 1'b0;
                fall_r <= 1'b0;
                cv_r   <= 1'b0;
            end else begin
                en_q <= 1'b1;
                if (toggle) begin
                    cnt    <= '0;
                    hcur   <= h_eff;
                    level  <= ~level;
                    rise_r <= going_up;
                    fall_r <= ~going_up;
                    cv_r   <= capture;
                    if (capture) begin
                        cap_r <= din;
                    end
                end else begin
                    cnt    <= cnt + ONE;
                    rise_r <= 1'b0;
                    fall_r <= 1'b0;
                    cv_r   <= 1'b0;
                    if (!en_q) begin
                        hcur <= h_eff;
                    end
                end
            end
        end

        assign clk_div[i]                   = level;
        assign rise[i]                      = rise_r;
        assign fall[i]                      = fall_r;
        assign cap_valid[i]                 = cv_r;
        assign cap_data[i*WIDTH +: WIDTH]   = cap_r;
    end

    always_comb begin
        mismatch = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (cap_valid[c] && (cap_data[c*WIDTH +: WIDTH] != din_q)) begin
                mismatch = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q <= '0;
            err   <= 1'b0;
        end else begin
            din_q <= din;
            err   <= err | mismatch;
        end
    end

endmodule

// File: tb/tb_clk_div_edge_capture.sv
// Bench for clk_div_edge_capture: scheduled-toggle reference model checked every cycle,
// directed timing scenarios pinned with literal values, then randomized traffic.
module tb_clk_div_edge_capture;
    localparam int NCH   = 4;
    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NCH-1:0]       enable;
    logic [NCH*CNT_W-1:0] half_per;
    logic [NCH*2-1:0]     edge_mode;
    logic [WIDTH-1:0]     din;
    logic [NCH-1:0]       clk_div;
    logic [NCH-1:0]       rise;
    logic [NCH-1:0]       fall;
    logic [NCH*WIDTH-1:0] cap_data;
    logic [NCH-1:0]       cap_valid;
    logic [WIDTH-1:0]     din_q;
    logic                 err;

    clk_div_edge_capture #(.NCH(NCH), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .half_per(half_per),
        .edge_mode(edge_mode), .din(din), .clk_div(clk_div), .rise(rise),
        .fall(fall), .cap_data(cap_data), .cap_valid(cap_valid), .din_q(din_q),
        .err(err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int pass_cnt  = 0;
    int total_cnt = 0;

    int               edge_no = 0;
    int               next_tog [NCH];
    logic             prev_en  [NCH];
    logic             m_div    [NCH];
    logic             m_rise   [NCH];
    logic             m_fall   [NCH];
    logic             m_cv     [NCH];
    logic [WIDTH-1:0] m_cap    [NCH];
    logic [WIDTH-1:0] m_dinq;
    logic [WIDTH-1:0] exp_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            next_tog[i] = 0;
            prev_en[i]  = 1'b0;
            m_div[i]    = 1'b0;
            m_rise[i]   = 1'b0;
            m_fall[i]   = 1'b0;
            m_cv[i]     = 1'b0;
            m_cap[i]    = '0;
        end
        m_dinq = '0;
        exp_q.delete();
    endtask

    // Each channel keeps the absolute edge number of its next toggle.
    task automatic model_step();
        int h;
        logic [1:0] md;
        edge_no++;
        for (int i = 0; i < NCH; i++) begin
            h = int'(half_per[i*CNT_W +: CNT_W]);
            if (h == 0) h = 1;
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            m_cv[i]   = 1'b0;
            if (!enable[i]) begin
                prev_en[i] = 1'b0;
            end else begin
                if (!prev_en[i]) begin
                    next_tog[i] = edge_no + h - 1;
                    prev_en[i]  = 1'b1;
                end
                if (edge_no == next_tog[i]) begin
                    m_div[i] = ~m_div[i];
                    if (m_div[i]) m_rise[i] = 1'b1;
                    else          m_fall[i] = 1'b1;
                    md = edge_mode[i*2 +: 2];
                    if ((m_rise[i] && md[0]) || (m_fall[i] && md[1])) begin
                        m_cap[i] = din;
                        m_cv[i]  = 1'b1;
                        if (i == 0) exp_q.push_back(din);
                    end
                    next_tog[i] = edge_no + h;
                end
            end
        end
        m_dinq = din;
    endtask

    task automatic compare_outputs();
        logic [NCH-1:0]       e_div, e_rise, e_fall, e_cv;
        logic [NCH*WIDTH-1:0] e_cap;
        for (int i = 0; i < NCH; i++) begin
            e_div[i]  = m_div[i];
            e_rise[i] = m_rise[i];
            e_fall[i] = m_fall[i];
            e_cv[i]   = m_cv[i];
            e_cap[i*WIDTH +: WIDTH] = m_cap[i];
        end
        chk("clk_div",   128'(clk_div),   128'(e_div));
        chk("rise",      128'(rise),      128'(e_rise));
        chk("fall",      128'(fall),      128'(e_fall));
        chk("cap_valid", 128'(cap_valid), 128'(e_cv));
        chk("cap_data",  128'(cap_data),  128'(e_cap));
        chk("din_q",     128'(din_q),     128'(m_dinq));
        chk("err",       128'(err),       128'(0));
        if (cap_valid[0]) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL cap_q: capture %h with empty expected queue", cap_data[WIDTH-1:0]);
            end else begin
                chk("cap_q", 128'(cap_data[WIDTH-1:0]), 128'(exp_q.pop_front()));
            end
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        compare_outputs();
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_tog(input int ch, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!(rise[ch] || fall[ch]) && n < 600);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int quiet;
        rst_n     = 1'b0;
        enable    = '0;
        half_per  = '0;
        edge_mode = '0;
        din       = '0;
        repeat (3) step();
        chk("reset_outputs", 128'({clk_div, rise, fall, cap_valid, err}), 128'(0));
        chk("reset_data", 128'({cap_data, din_q}), 128'(0));
        rst_n = 1'b1;
        step();

        // ch0 H=1 both edges, ch1 H=3 rise only
        enable    = 4'b0011;
        half_per  = {8'd0, 8'd0, 8'd3, 8'd1};
        edge_mode = 8'b0000_0111;
        din = 32'hA000_0001; step();
        chk("h1_first_toggle", 128'({clk_div[0], rise[0], cap_valid[0]}), 128'(3'b111));
        chk("h1_first_cap", 128'(cap_data[31:0]), 128'(32'hA000_0001));
        din = 32'hA000_0002; step();
        chk("h1_fall_cap", 128'({clk_div[0], fall[0], cap_valid[0]}), 128'(3'b011));
        chk("h3_idle", 128'({clk_div[1], rise[1]}), 128'(0));
        din = 32'hA000_0003; step();
        chk("h3_rise", 128'({clk_div[1], rise[1], cap_valid[1]}), 128'(3'b111));
        chk("h3_rise_cap", 128'(cap_data[63:32]), 128'(32'hA000_0003));
        din = 32'hA000_0004; step();
        din = 32'hA000_0005; step();
        din = 32'hA000_0006; step();
        chk("h3_fall_nocap", 128'({clk_div[1], fall[1], cap_valid[1]}), 128'(3'b010));
        chk("h3_cap_held", 128'(cap_data[63:32]), 128'(32'hA000_0003));

        // half-period change mid-way through a half: old value finishes first
        step();
        half_per[15:8] = 8'd5;
        wait_tog(1, n);
        chk("hp_change_old_gap", 128'(n + 1), 128'(3));
        wait_tog(1, n);
        chk("hp_change_new_gap", 128'(n), 128'(5));

        // ch0 half_per 0 behaves as 1; ch2 maximum half-period
        half_per[7:0]   = 8'd0;
        half_per[23:16] = 8'd255;
        edge_mode[5:4]  = 2'b11;
        enable[2]       = 1'b1;
        wait_tog(2, n);
        chk("h255_first", 128'(n), 128'(255));
        wait_tog(2, n);
        chk("h255_gap", 128'(n), 128'(255));

        // ch3 disable while high, then resume
        half_per[31:24] = 8'd2;
        edge_mode[7:6]  = 2'b11;
        enable[3]       = 1'b1;
        wait_tog(3, n);
        chk("h2_first", 128'({n[7:0], clk_div[3]}), 128'({8'd2, 1'b1}));
        enable[3] = 1'b0;
        quiet = 0;
        repeat (10) begin
            step();
            if (rise[3] || fall[3] || cap_valid[3] || !clk_div[3]) quiet++;
        end
        chk("disable_quiet", 128'(quiet), 128'(0));
        enable[3] = 1'b1;
        wait_tog(3, n);
        chk("resume_fall", 128'({n[7:0], fall[3], clk_div[3]}), 128'({8'd2, 1'b1, 1'b0}));

        // randomized traffic
        enable = 4'hF;
        for (int c = 0; c < 3000; c++) begin
            int k;
            din = $urandom;
            if ($urandom_range(0, 19) == 0) begin
                k = $urandom_range(0, NCH - 1);
                enable[k] = ~enable[k];
            end
            if ($urandom_range(0, 29) == 0) begin
                k = $urandom_range(0, NCH - 1);
                case ($urandom_range(0, 4))
                    0:       half_per[k*CNT_W +: CNT_W] = 8'd0;
                    1:       half_per[k*CNT_W +: CNT_W] = 8'd1;
                    2:       half_per[k*CNT_W +: CNT_W] = 8'd2;
                    3:       half_per[k*CNT_W +: CNT_W] = 8'd3;
                    default: half_per[k*CNT_W +: CNT_W] = 8'($urandom_range(4, 12));
                endcase
            end
            if ($urandom_range(0, 14) == 0) begin
                k = $urandom_range(0, NCH - 1);
                edge_mode[k*2 +: 2] = 2'($urandom_range(0, 3));
            end
            step();
        end

        // asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", 128'({clk_div, rise, fall, cap_valid, err}), 128'(0));
        chk("async_rst_data", 128'({cap_data, din_q}), 128'(0));
        enable        = 4'b0001;
        half_per[7:0] = 8'd4;
        edge_mode     = 8'hFF;
        step();
        step();
        rst_n = 1'b1;
        wait_tog(0, n);
        chk("post_reset_first", 128'({n[7:0], rise[0]}), 128'({8'd4, 1'b1}));
        repeat (20) step();

        chk("err_final", 128'(err), 128'(0));
        chk("cap_q_drained", 128'(exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
